// File: rtl/pwm_meter.sv
// pwm_meter: measures an incoming asynchronous pulse train.
//
// Synchronizes sig_in, detects rising edges and reports, for each complete
// period between two rising edges, the period length and the high time in
// clock cycles together with the duty cycle in integer percent. A line that
// shows no rising edge for TIMEOUT_CYC cycles is flagged as stuck.
//
// Ports:
//   clk_in      system clock
//   rst         asynchronous, active-high reset
//   sig_in      asynchronous pulse input
//   period_out  last measured period, in cycles
//   high_out    last measured high time, in cycles
//   duty_pct    floor(high_out*100/period_out), 0..100
//   meas_valid  one-cycle pulse in the cycle the three outputs above change
//   stuck       high while no rising edge arrived within TIMEOUT_CYC cycles
//   stuck_level synchronized input level captured when stuck asserted
//   overrun     one-cycle pulse when a measurement is dropped (edge mid-divide)
module pwm_meter #(
  parameter int CLK_IN_HZ   = 100000000,
  parameter int TIMEOUT_CYC = CLK_IN_HZ / 10,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic             overrun
);

  localparam int NUM_W = CNT_W + 7;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {ARM, MEAS, DIV} state_t;

  state_t state, state_nxt;

  logic sync1, sync2, sync3;
  logic rise;

  logic [CNT_W-1:0] cnt, hcnt;
  logic [CNT_W-1:0] per_lat, hi_lat;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [6:0]       num_lo, quo;
  logic [2:0]       step;
  logic             tmo_pend;
  logic             at_tmo;

  logic [NUM_W-1:0] num_full;
  logic [CNT_W:0]   trial;
  logic             q_bit;

  logic arm_start, meas_done, meas_tmo;
  logic div_run, div_last, div_ovr, div_tmo, div_to_arm;

  assign rise   = sync2 & ~sync3;
  assign at_tmo = (cnt == TMO);

  // Numerator H*100 for the divider. Because the quotient never exceeds 100
  // (< 128), the bits above the low seven already form a partial remainder
  // smaller than the divisor, so only seven restoring steps are needed.
  assign num_full = NUM_W'(hcnt) * NUM_W'(100);

  // One restoring-division step: bring down the next numerator bit and
  // subtract the divisor when it fits.
  always_comb begin
    trial   = {rem, num_lo[6]};
    q_bit   = (trial >= {1'b0, per_lat});
    rem_nxt = q_bit ? CNT_W'(trial - {1'b0, per_lat}) : trial[CNT_W-1:0];
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= ARM;
    else     state <= state_nxt;
  end

  // Next-state logic. A rise always beats a coincident timeout; a timeout
  // seen while dividing is deferred until the result has been published.
  always_comb begin
    state_nxt = state;
    case (state)
      ARM:  if (rise) state_nxt = MEAS;
      MEAS: begin
        if (rise)        state_nxt = DIV;
        else if (at_tmo) state_nxt = ARM;
      end
      DIV:  if (step == 3'd6)
              state_nxt = (!rise && (tmo_pend || at_tmo)) ? ARM : MEAS;
      default: state_nxt = ARM;
    endcase
  end

  // FSM output decode: control strobes for the datapath.
  always_comb begin
    arm_start  = 1'b0;
    meas_done  = 1'b0;
    meas_tmo   = 1'b0;
    div_run    = 1'b0;
    div_last   = 1'b0;
    div_ovr    = 1'b0;
    div_tmo    = 1'b0;
    div_to_arm = 1'b0;
    case (state)
      ARM:  arm_start = rise;
      MEAS: begin
        meas_done = rise;
        meas_tmo  = !rise && at_tmo;
      end
      DIV:  begin
        div_run    = 1'b1;
        div_last   = (step == 3'd6);
        div_ovr    = rise;
        div_tmo    = !rise && at_tmo;
        div_to_arm = (step == 3'd6) && !rise && (tmo_pend || at_tmo);
      end
      default: ;
    endcase
  end

  // Datapath: synchronizer, counters, divider and published results.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      cnt         <= '0;
      hcnt        <= '0;
      per_lat     <= '0;
      hi_lat      <= '0;
      rem         <= '0;
      num_lo      <= '0;
      quo         <= '0;
      step        <= '0;
      tmo_pend    <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      duty_pct    <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
      stuck       <= 1'b1;
      stuck_level <= 1'b0;
    end else begin
      sync1      <= sig_in;
      sync2      <= sync1;
      sync3      <= sync2;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;

      // The rise cycle itself is high, so both counters restart at 1. They
      // saturate at the timeout value, which keeps them from ever wrapping.
      if (arm_start || meas_done || div_ovr) begin
        cnt  <= CNT_W'(1);
        hcnt <= CNT_W'(1);
      end else if (state != ARM && !at_tmo) begin
        cnt  <= cnt + CNT_W'(1);
        hcnt <= hcnt + CNT_W'(sync2);
      end

      if (meas_done) begin
        per_lat <= cnt;
        hi_lat  <= hcnt;
        rem     <= num_full[NUM_W-1:7];
        num_lo  <= num_full[6:0];
        quo     <= '0;
        step    <= '0;
      end

      if (div_run) begin
        rem    <= rem_nxt;
        num_lo <= {num_lo[5:0], 1'b0};
        quo    <= {quo[5:0], q_bit};
        step   <= step + 3'd1;
      end

      // The last quotient bit goes straight to duty_pct so the new results
      // and meas_valid appear together.
      if (div_last) begin
        period_out <= per_lat;
        high_out   <= hi_lat;
        duty_pct   <= {quo[5:0], q_bit};
        meas_valid <= 1'b1;
      end

      if (div_ovr) overrun <= 1'b1;

      if (arm_start) begin
        stuck <= 1'b0;
      end else if (meas_tmo || div_to_arm) begin
        stuck       <= 1'b1;
        stuck_level <= sync2;
      end

      if (div_tmo && !div_last)
        tmo_pend <= 1'b1;
      else if (state != DIV || div_last || div_ovr)
        tmo_pend <= 1'b0;
    end
  end

endmodule

// File: doc/pwm_meter.md
Name: pwm_meter

Overview:
- Input-side counterpart of the LED blink/PWM generators: measures an incoming pulse train (external PWM, blink pin loop-back, button line).
- Reports the period in clock cycles, the high time, and the duty cycle in integer percent.
- Flags a stuck line (no rising edge within a timeout).
- Sits between an asynchronous pad and status/debug logic such as the HDMI overlay.

Parameters:
- CLK_IN_HZ, 100000000, input clock frequency.
- TIMEOUT_CYC, CLK_IN_HZ/10, cycles without a rising edge before the line is declared stuck.
- CNT_W, $clog2(TIMEOUT_CYC+1), width of the period and high counters.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sig_in  in  1  asynchronous pulse input.
- period_out  out  CNT_W  last measured period, in cycles.
- high_out  out  CNT_W  last measured high time, in cycles.
- duty_pct  out  7  floor(high_out*100/period_out), range 0..100.
- meas_valid  out  1  one-cycle pulse when the three outputs above update.
- stuck  out  1  level; high while no rising edge has arrived within TIMEOUT_CYC.
- stuck_level  out  1  synchronized sig_in level, captured when stuck asserts.
- overrun  out  1  one-cycle pulse when a measurement is dropped.

Behaviour:
- Reset (async, active-high) clears all outputs and internal registers to 0, except stuck = 1. The FSM enters ARM.
- Input path:
  - 2-FF synchronizer (reset 0), then one edge register.
  - A rise is detected in cycle R, defined as 3 clk_in edges after sig_in goes high.
  - Only rising edges are used.
- FSM states: ARM, MEAS, DIV.
  - ARM: wait for the first rise. On rise: cnt <= 1, hcnt <= 1, stuck <= 0, go to MEAS. No result is produced.
  - MEAS: cnt +1 every cycle. hcnt +1 every cycle the synced signal is high.
  - MEAS, on rise: latch P = cnt and H = hcnt. Restart cnt <= 1, hcnt <= 1. Go to DIV.
  - MEAS, cnt == TIMEOUT_CYC with no rise: stuck <= 1, stuck_level <= synced sig, go to ARM. Outputs hold their last values.
  - DIV: restoring divider on numerator H*100 (CNT_W+7 bits) by P. It produces 7 quotient bits MSB-first, one per cycle, in cycles R+1..R+7.
  - Counting continues during DIV, including timeout checks.
  - Cycle R+8: period_out <= P, high_out <= H, duty_pct <= quotient, meas_valid = 1 for that cycle. Return to MEAS.
  - Timeout during DIV: the divide completes and its result is published, then the FSM goes to ARM with stuck = 1.
- Overrun:
  - A rise in R+1..R+7 pulses overrun for 1 cycle, and its period is discarded.
  - Counters still restart on that rise, so the following period is measured normally.
  - The minimum measurable period is 8 cycles.
- Arithmetic:
  - H <= P always holds, so the quotient is <= 100.
  - H == P gives 100. A line that is low except for a 1-cycle high gives H = 1.
  - Counters never wrap: timeout fires first.
- Rise and timeout in the same cycle: the rise wins (measurement taken, no stuck).
- Reset mid-divide: result discarded, no meas_valid.

Test Plan:
- Reset release with sig_in = 0 → stuck = 1, all other outputs 0, no meas_valid until the second rise.
- Square wave, period 20, high 5 → meas_valid every 20 cycles; period_out = 20, high_out = 5, duty_pct = 25. First result at R2+8, where R2 is the second rise detect.
- Period 300, high 299 → duty_pct = 99 (floor check). Period 7 → overrun on every second rise, no corrupt outputs. Period 8 → valid every edge, no overrun.
- Stop toggling high (TIMEOUT_CYC set to 1000 for sim) → stuck = 1 exactly 1000 cycles after the last rise-detect cycle; stuck_level = 1; last outputs held. Resume toggling → stuck = 0 at the first rise, valid result after the second.
- Assert rst at R+4 of a divide → all outputs immediately 0, stuck = 1, no meas_valid pulse afterwards.
- Random asynchronous jittered input, 10k periods → scoreboard of period/high/duty vs. a model on synced edges, zero mismatches.
